// File: rtl/axi_noc_mem_responder_m.sv
// AXI4 subordinate endpoint for NoC tests: write bursts land in a register-array memory,
// read bursts return stored words. Write and read channels run independent single-outstanding FSMs.
`ifndef BASE_ADDRESS
`define BASE_ADDRESS 64'h0
`endif

module axi_noc_mem_responder_m #(
   parameter int          DATA_W    = 64,
   parameter int          DEPTH     = 256,
   parameter logic [63:0] BASE_ADDR = `BASE_ADDRESS
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  awvalid,
   output logic                  awready,
   input  logic [63:0]           awaddr,
   input  logic [7:0]            awlen,
   input  logic [2:0]            awsize,
   input  logic [1:0]            awburst,
   input  logic [1:0]            awid,
   input  logic                  wvalid,
   output logic                  wready,
   input  logic [DATA_W-1:0]     wdata,
   input  logic [DATA_W/8-1:0]   wstrb,
   input  logic                  wlast,
   output logic                  bvalid,
   input  logic                  bready,
   output logic [1:0]            bresp,
   output logic [1:0]            bid,
   input  logic                  arvalid,
   output logic                  arready,
   input  logic [63:0]           araddr,
   input  logic [7:0]            arlen,
   input  logic [2:0]            arsize,
   input  logic [1:0]            arburst,
   input  logic [1:0]            arid,
   output logic                  rvalid,
   input  logic                  rready,
   output logic [DATA_W-1:0]     rdata,
   output logic [1:0]            rresp,
   output logic [1:0]            rid,
   output logic                  rlast,
   output logic [1:0]            err
);

   localparam int WSTRB_W = DATA_W / 8;
   localparam int BSH     = $clog2(WSTRB_W);
   localparam int IDX_W   = $clog2(DEPTH);
   localparam logic [1:0] BURST_INCR = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   // Handshakes: a beat transfers on the rising edge where valid && ready are both high.
   // Ready/valid outputs are pure functions of FSM state, forced low while rst is asserted.

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
   typedef enum logic [0:0] {R_IDLE, R_DATA} r_state_t;

   w_state_t             w_state_q, w_state_d;
   r_state_t             r_state_q, r_state_d;

   logic [IDX_W-1:0]     w_idx_q, r_idx_q;
   logic [7:0]           w_len_q, w_cnt_q, r_len_q, r_cnt_q;
   logic                 w_incr_q, w_bad_q, w_err_q;
   logic                 r_incr_q, r_bad_q;

   logic [DATA_W-1:0]    mem [DEPTH];

   logic                 aw_hs, w_hs, ar_hs, r_hs;
   logic                 aw_bad, ar_bad, w_last_beat, wlast_mis;
   logic [IDX_W-1:0]     aw_idx, ar_idx;

   assign aw_idx = IDX_W'((awaddr - BASE_ADDR) >> BSH);
   assign ar_idx = IDX_W'((araddr - BASE_ADDR) >> BSH);
   // WRAP and RESERVED both have burst[1] set; only full-width beats are supported.
   assign aw_bad = awburst[1] || (awsize != 3'(BSH));
   assign ar_bad = arburst[1] || (arsize != 3'(BSH));

   assign aw_hs       = awvalid && awready;
   assign w_hs        = wvalid && wready;
   assign ar_hs       = arvalid && arready;
   assign r_hs        = rvalid && rready;
   assign w_last_beat = (w_cnt_q == w_len_q);
   assign wlast_mis   = w_hs && (wlast != w_last_beat);

   always_comb begin
      w_state_d = w_state_q;
      awready   = 1'b0;
      wready    = 1'b0;
      bvalid    = 1'b0;
      bresp     = 2'b00;
      case (w_state_q)
         W_IDLE: begin
            awready = !rst;
            if (awvalid && awready) w_state_d = W_DATA;
         end
         W_DATA: begin
            wready = !rst;
            if (wvalid && wready && w_last_beat) w_state_d = W_RESP;
         end
         W_RESP: begin
            bvalid = !rst;
            if (bvalid) bresp = (w_err_q || w_bad_q) ? RESP_SLVERR : 2'b00;
            if (bvalid && bready) w_state_d = W_IDLE;
         end
         default: w_state_d = W_IDLE;
      endcase
   end

   always_comb begin
      r_state_d = r_state_q;
      arready   = 1'b0;
      rvalid    = 1'b0;
      rlast     = 1'b0;
      rresp     = 2'b00;
      rdata     = '0;
      case (r_state_q)
         R_IDLE: begin
            arready = !rst;
            if (arvalid && arready) r_state_d = R_DATA;
         end
         R_DATA: begin
            rvalid = !rst;
            if (rvalid) begin
               rlast = (r_cnt_q == r_len_q);
               rresp = r_bad_q ? RESP_SLVERR : 2'b00;
               rdata = r_bad_q ? '0 : mem[r_idx_q];
            end
            if (rvalid && rready && rlast) r_state_d = R_IDLE;
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         w_state_q <= W_IDLE;
         r_state_q <= R_IDLE;
         w_idx_q   <= '0;
         w_len_q   <= '0;
         w_cnt_q   <= '0;
         w_incr_q  <= 1'b0;
         w_bad_q   <= 1'b0;
         w_err_q   <= 1'b0;
         r_idx_q   <= '0;
         r_len_q   <= '0;
         r_cnt_q   <= '0;
         r_incr_q  <= 1'b0;
         r_bad_q   <= 1'b0;
         bid       <= 2'b00;
         rid       <= 2'b00;
         err       <= 2'b00;
      end else begin
         w_state_q <= w_state_d;
         r_state_q <= r_state_d;
         err       <= err | {(aw_hs && aw_bad) || (ar_hs && ar_bad), wlast_mis};
         if (aw_hs) begin
            w_idx_q  <= aw_idx;
            w_len_q  <= awlen;
            w_cnt_q  <= '0;
            w_incr_q <= (awburst == BURST_INCR);
            w_bad_q  <= aw_bad;
            w_err_q  <= 1'b0;
            bid      <= awid;
         end else if (w_hs) begin
            w_cnt_q <= w_cnt_q + 8'd1;
            if (w_incr_q) w_idx_q <= w_idx_q + 1'b1;
            if (wlast_mis) w_err_q <= 1'b1;
         end
         if (ar_hs) begin
            r_idx_q  <= ar_idx;
            r_len_q  <= arlen;
            r_cnt_q  <= '0;
            r_incr_q <= (arburst == BURST_INCR);
            r_bad_q  <= ar_bad;
            rid      <= arid;
         end else if (r_hs) begin
            r_cnt_q <= r_cnt_q + 8'd1;
            if (r_incr_q) r_idx_q <= r_idx_q + 1'b1;
         end
      end
   end

   // Memory is deliberately not reset; beats written before an abort survive it.
   always_ff @(posedge clk) begin
      if (w_hs && !w_bad_q) begin
         for (int b = 0; b < WSTRB_W; b++) begin
            if (wstrb[b]) mem[w_idx_q][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
   end

endmodule

// File: tb/tb_axi_noc_mem_responder_m.sv
// Directed bench for axi_noc_mem_responder_m: bursts checked against a word model and expected queue,
// with immediate assertions at every comparison point.
module tb_axi_noc_mem_responder_m;

   localparam int          DATA_W = 64;
   localparam int          DEPTH  = 256;
   localparam logic [63:0] BASE   = 64'h0000_0000_8000_0000;
   localparam logic [1:0]  FIXED  = 2'b00;
   localparam logic [1:0]  INCR   = 2'b01;
   localparam logic [1:0]  WRAP   = 2'b10;
   localparam logic [1:0]  OKAY   = 2'b00;
   localparam logic [1:0]  SLVERR = 2'b10;
   localparam int          BUDGET = 200;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              awvalid = 0, awready;
   logic [63:0]       awaddr = 0;
   logic [7:0]        awlen = 0;
   logic [2:0]        awsize = 0;
   logic [1:0]        awburst = 0, awid = 0;
   logic              wvalid = 0, wready, wlast = 0;
   logic [DATA_W-1:0] wdata = 0;
   logic [7:0]        wstrb = 0;
   logic              bvalid, bready = 0;
   logic [1:0]        bresp, bid;
   logic              arvalid = 0, arready;
   logic [63:0]       araddr = 0;
   logic [7:0]        arlen = 0;
   logic [2:0]        arsize = 0;
   logic [1:0]        arburst = 0, arid = 0;
   logic              rvalid, rready = 0, rlast;
   logic [DATA_W-1:0] rdata;
   logic [1:0]        rresp, rid, err;

   int checks = 0;
   int errors = 0;
   logic [DATA_W-1:0] model [DEPTH];
   logic [DATA_W-1:0] exp_q [$];

   axi_noc_mem_responder_m #(.DATA_W(DATA_W), .DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
      .clk(clk), .rst(rst),
      .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
      .awsize(awsize), .awburst(awburst), .awid(awid),
      .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
      .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
      .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
      .arsize(arsize), .arburst(arburst), .arid(arid),
      .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rid(rid),
      .rlast(rlast), .err(err)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      errors++;
      $display("FAIL watchdog observed=timeout required=finish");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] word_idx(input logic [63:0] addr);
      logic [63:0] off;
      off = (addr - BASE) / 8;
      return off[7:0];
   endfunction

   // Tasks start and end at a falling edge; inputs change there, transfers happen on the next rise.
   task automatic do_write(input logic [63:0] addr, input int len, input logic [1:0] burst,
                           input logic [2:0] size, input logic [1:0] id, input logic [63:0] data0,
                           input int last_beat, input bit bp, input logic [1:0] exp_resp,
                           input int abort_beat);
      int n;
      logic [7:0] idx;
      bit ok;
      idx = word_idx(addr);
      ok = (burst == INCR || burst == FIXED) && size == 3'd3;
      awaddr = addr; awlen = 8'(len); awburst = burst; awsize = size; awid = id; awvalid = 1'b1;
      n = 0;
      while (!awready && n < BUDGET) begin @(negedge clk); n++; end
      check("aw_handshake_timeout", 64'(n >= BUDGET), 0);
      @(negedge clk);
      awvalid = 1'b0;
      for (int i = 0; i <= len; i++) begin
         wdata = data0 + 64'(i); wstrb = 8'hFF; wlast = (i == last_beat); wvalid = 1'b1;
         if (i == abort_beat) begin
            rst = 1'b1;
            @(negedge clk);
            check("rst_awready", awready, 0);
            check("rst_wready", wready, 0);
            check("rst_bvalid", bvalid, 0);
            check("rst_arready", arready, 0);
            check("rst_rvalid", rvalid, 0);
            check("rst_rlast", rlast, 0);
            check("rst_err", err, 0);
            rst = 1'b0; wvalid = 1'b0; wlast = 1'b0;
            @(negedge clk);
            check("post_rst_awready", awready, 1);
            return;
         end
         n = 0;
         while (!wready && n < BUDGET) begin @(negedge clk); n++; end
         check("w_handshake_timeout", 64'(n >= BUDGET), 0);
         if (ok) begin
            model[idx] = data0 + 64'(i);
            if (burst == INCR) idx = idx + 8'd1;
         end
         @(negedge clk);
      end
      wvalid = 1'b0; wlast = 1'b0;
      check("wready_after_len_beats", wready, 0);
      check("bvalid_after_len_beats", bvalid, 1);
      if (bp) begin
         repeat ($urandom_range(0, 3)) begin
            @(negedge clk);
            check("bvalid_held", bvalid, 1);
         end
      end
      check("bresp", bresp, exp_resp);
      check("bid", bid, id);
      bready = 1'b1;
      @(negedge clk);
      bready = 1'b0;
      check("bvalid_cleared", bvalid, 0);
   endtask

   task automatic do_read(input logic [63:0] addr, input int len, input logic [1:0] burst,
                          input logic [2:0] size, input logic [1:0] id, input bit bp,
                          input logic [1:0] exp_resp);
      int n, i;
      logic [7:0] idx;
      logic [DATA_W-1:0] hold_data, exp_data;
      logic hold_last;
      bit ok;
      idx = word_idx(addr);
      ok = (burst == INCR || burst == FIXED) && size == 3'd3;
      for (int k = 0; k <= len; k++) begin
         exp_q.push_back(ok ? model[idx] : '0);
         if (burst == INCR) idx = idx + 8'd1;
      end
      araddr = addr; arlen = 8'(len); arburst = burst; arsize = size; arid = id; arvalid = 1'b1;
      n = 0;
      while (!arready && n < BUDGET) begin @(negedge clk); n++; end
      check("ar_handshake_timeout", 64'(n >= BUDGET), 0);
      @(negedge clk);
      arvalid = 1'b0;
      check("rvalid_first_beat", rvalid, 1);
      i = 0;
      n = 0;
      while (i <= len && n < BUDGET) begin
         if (!rvalid) begin
            n++;
            @(negedge clk);
         end else if (bp && $urandom_range(0, 1) == 0) begin
            rready = 1'b0;
            hold_data = rdata; hold_last = rlast;
            @(negedge clk);
            check("rdata_stable_stalled", rdata, hold_data);
            check("rlast_stable_stalled", rlast, hold_last);
         end else begin
            n = 0;
            rready = 1'b1;
            exp_data = exp_q.pop_front();
            check("rdata", rdata, exp_data);
            check("rresp", rresp, exp_resp);
            check("rid", rid, id);
            check("rlast", rlast, 64'(i == len));
            @(negedge clk);
            rready = 1'b0;
            i++;
         end
      end
      check("r_beat_timeout", 64'(n >= BUDGET), 0);
      check("rvalid_after_last", rvalid, 0);
      check("exp_q_drained", exp_q.size(), 0);
      exp_q.delete();
   endtask

   initial begin
      for (int k = 0; k < DEPTH; k++) model[k] = 'x;
      repeat (3) @(negedge clk);
      check("reset_awready", awready, 0);
      check("reset_wready", wready, 0);
      check("reset_bvalid", bvalid, 0);
      check("reset_arready", arready, 0);
      check("reset_rvalid", rvalid, 0);
      check("reset_rlast", rlast, 0);
      check("reset_bresp", bresp, 0);
      check("reset_rresp", rresp, 0);
      check("reset_bid", bid, 0);
      check("reset_rid", rid, 0);
      check("reset_err", err, 0);
      rst = 1'b0;
      @(negedge clk);
      check("idle_awready", awready, 1);
      check("idle_arready", arready, 1);

      // 200-beat write then read back, full throughput
      do_write(BASE, 199, INCR, 3'd3, 2'd1, 64'd16, 199, 1'b0, OKAY, -1);
      check("err_after_write", err, 0);
      do_read(BASE, 199, INCR, 3'd3, 2'd2, 1'b0, OKAY);

      // same traffic under random backpressure
      do_write(BASE, 199, INCR, 3'd3, 2'd3, 64'd16, 199, 1'b1, OKAY, -1);
      do_read(BASE, 199, INCR, 3'd3, 2'd0, 1'b1, OKAY);
      check("err_after_bp", err, 0);

      // index wrap at the top of memory
      do_write(BASE + 64'(8 * (DEPTH - 2)), 3, INCR, 3'd3, 2'd0, 64'hA0, 3, 1'b0, OKAY, -1);
      do_read(BASE + 64'(8 * (DEPTH - 2)), 3, INCR, 3'd3, 2'd1, 1'b0, OKAY);
      do_read(BASE + 64'd16, 0, INCR, 3'd3, 2'd1, 1'b0, OKAY);

      // FIXED burst lands every beat on one word
      do_write(BASE + 64'(8 * 20), 2, FIXED, 3'd3, 2'd2, 64'h700, 2, 1'b0, OKAY, -1);
      do_read(BASE + 64'(8 * 20), 0, INCR, 3'd3, 2'd2, 1'b0, OKAY);
      do_read(BASE + 64'(8 * 21), 0, INCR, 3'd3, 2'd2, 1'b0, OKAY);

      // early wlast: length follows awlen, SLVERR, err[0]
      do_write(BASE + 64'(8 * 10), 4, INCR, 3'd3, 2'd1, 64'h500, 2, 1'b0, SLVERR, -1);
      check("err_wlast", err, 2'b01);
      do_read(BASE + 64'(8 * 10), 4, INCR, 3'd3, 2'd1, 1'b0, OKAY);

      // WRAP read: beats complete with zero data and SLVERR, err[1]
      do_read(BASE, 3, WRAP, 3'd3, 2'd2, 1'b0, SLVERR);
      check("err_wrap", err, 2'b11);

      // narrow-size write is rejected and leaves memory untouched
      do_write(BASE + 64'(8 * 30), 1, INCR, 3'd2, 2'd3, 64'hDEAD, 1, 1'b0, SLVERR, -1);
      do_read(BASE + 64'(8 * 30), 1, INCR, 3'd3, 2'd3, 1'b0, OKAY);

      // reset during beat 10 of a 200-beat write; beats 0..9 persist
      do_write(BASE + 64'(8 * 40), 199, INCR, 3'd3, 2'd1, 64'h900, 199, 1'b0, OKAY, 10);
      do_write(BASE + 64'(8 * 100), 4, INCR, 3'd3, 2'd2, 64'hB00, 4, 1'b0, OKAY, -1);
      check("err_after_reset_burst", err, 0);
      do_read(BASE + 64'(8 * 38), 14, INCR, 3'd3, 2'd0, 1'b0, OKAY);
      do_read(BASE + 64'(8 * 100), 4, INCR, 3'd3, 2'd3, 1'b1, OKAY);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
